md_unit: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
- Sits beside the EX-stage ALU and accepts MULT/MULTU/DIV/DIVU, MTHI and MTLO from EX.
- Raises a stall request toward the hazard unit while an operation is in flight.
- WIDTH is parametrised; no multi-cycle arithmetic existed in the core before this block.

---
 rtl/md_pkg.sv | 33 +++
 rtl/md_sign_fix.sv | 41 ++++
 rtl/md_unit.sv | 231 +++++++++++++++++++++++
 tb/tb_md_unit.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   - op encodings carried on op_i
//   - FSM state enum
//   - LO value written on divide by zero
//   - small op-decode helpers
package md_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_FIX  = 2'b11
  } md_state_t;

  localparam int unsigned MD_MAX_WIDTH = 64;

  // All ones; sliced down to WIDTH at the point of use.
  localparam logic [MD_MAX_WIDTH-1:0] MD_DZ_LO = '1;

  function automatic logic md_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// md_sign_fix: conditional two's-complement negate on two WIDTH lanes.
//   wide_i=0 : hi and lo negated independently by neg_hi_i / neg_lo_i
//   wide_i=1 : {hi,lo} negated as one 2*WIDTH value under neg_lo_i
// Ports:
//   wide_i, neg_hi_i, neg_lo_i  in  control
//   hi_i, lo_i                  in  WIDTH  values
//   hi_o, lo_o                  out WIDTH  corrected values (combinational)
module md_sign_fix
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             wide_i,
  input  logic             neg_hi_i,
  input  logic             neg_lo_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] lo_neg;
  logic [WIDTH-1:0] hi_neg_lane;
  logic [WIDTH-1:0] hi_neg_wide;
  logic             lo_zero;

  // In wide mode the +1 of the negate only ripples into hi when lo is zero.
  always_comb begin
    lo_neg      = ~lo_i + WIDTH'(1);
    lo_zero     = (lo_i == '0);
    hi_neg_lane = ~hi_i + WIDTH'(1);
    hi_neg_wide = ~hi_i + WIDTH'(lo_zero);
    lo_o        = neg_lo_i ? lo_neg : lo_i;
    if (wide_i) begin
      hi_o = neg_lo_i ? hi_neg_wide : hi_i;
    end else begin
      hi_o = neg_hi_i ? hi_neg_lane : hi_i;
    end
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit with architectural HI/LO.
//   MUL: radix-2 shift-add, DIV: restoring, both one bit per cycle, then a
//   sign-correction cycle (FIX) that writes HI/LO and pulses done_o.
// Optional feature macro: MDU_EARLY_OUT_EN (multiply finishes once the
//   remaining multiplier bits are all zero).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start_i, op_i, a_i, b_i  operation issue
//   mthi_i, mtlo_i, wdata_i  direct HI/LO writes
//   mf_req_i                 MFHI/MFLO waiting in EX
//   hi_o, lo_o               HI/LO registers
//   busy_o, done_o, dz_o     status (registered)
//   stall_o                  pipeline hold request (combinational)
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             mf_req_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             stall_o,
  output logic             dz_o
);

`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  md_state_t          state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   bop_q, bop_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;

  logic               op_signed;
  logic               op_div;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] mul_nx;
  logic [2*WIDTH-1:0] div_nx;
  logic [2*WIDTH-1:0] step_nx;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic               mul_last;
  logic               div_last;

  assign op_signed = md_is_signed(op_i);
  assign op_div    = md_is_div(op_i);

  // Operand magnitudes for signed ops.
  md_sign_fix #(.WIDTH(WIDTH)) u_abs (
    .wide_i   (1'b0),
    .neg_hi_i (op_signed & a_i[WIDTH-1]),
    .neg_lo_i (op_signed & b_i[WIDTH-1]),
    .hi_i     (a_i),
    .lo_i     (b_i),
    .hi_o     (abs_a),
    .lo_o     (abs_b)
  );

  // One iteration of either algorithm; acc holds {rem, quotient} for divide.
  always_comb begin
    mul_nx = bop_q[0] ? (acc_q + mcand_q) : acc_q;
    rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, bop_q};
    if (trial[WIDTH]) begin
      div_nx = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_nx = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
    step_nx = is_div_q ? div_nx : mul_nx;
  end

  // Sign correction of the final iteration's result, written straight to HI/LO.
  md_sign_fix #(.WIDTH(WIDTH)) u_res (
    .wide_i   (~is_div_q),
    .neg_hi_i (rneg_q),
    .neg_lo_i (qneg_q),
    .hi_i     (step_nx[2*WIDTH-1:WIDTH]),
    .lo_i     (step_nx[WIDTH-1:0]),
    .hi_o     (res_hi),
    .lo_o     (res_lo)
  );

  assign div_last = (cnt_q == CNT_W'(WIDTH - 1));
  assign mul_last = div_last || (EARLY_OUT && (bop_q[WIDTH-1:1] == '0));

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    bop_d    = bop_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    case (state_q)
      // FIX is the done cycle; busy is already low so it accepts like IDLE.
      ST_IDLE, ST_FIX: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (start_i) begin
          is_div_d = op_div;
          qneg_d   = op_signed & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          rneg_d   = op_signed & a_i[WIDTH-1];
          cnt_d    = '0;
          bop_d    = abs_b;
          if (op_div && (b_i == '0)) begin
            state_d = ST_FIX;
            hi_d    = a_i;
            lo_d    = MD_DZ_LO[WIDTH-1:0];
            done_d  = 1'b1;
            dz_d    = 1'b1;
          end else if (op_div) begin
            state_d = ST_DIV;
            busy_d  = 1'b1;
            acc_d   = {{WIDTH{1'b0}}, abs_a};
          end else begin
            state_d = ST_MUL;
            busy_d  = 1'b1;
            acc_d   = '0;
            mcand_d = {{WIDTH{1'b0}}, abs_a};
          end
        end else begin
          if (mthi_i) hi_d = wdata_i;
          if (mtlo_i) lo_d = wdata_i;
        end
      end
      ST_MUL: begin
        acc_d   = step_nx;
        mcand_d = mcand_q << 1;
        bop_d   = bop_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (mul_last) begin
          state_d = ST_FIX;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hi_d    = res_hi;
          lo_d    = res_lo;
        end
      end
      ST_DIV: begin
        acc_d = step_nx;
        cnt_d = cnt_q + CNT_W'(1);
        if (div_last) begin
          state_d = ST_FIX;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hi_d    = res_hi;
          lo_d    = res_lo;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      bop_q    <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      bop_q    <= bop_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
    end
  end

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign dz_o    = dz_q;
  assign stall_o = busy_q & (start_i | mf_req_i | mthi_i | mtlo_i);

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and randomized checks of md_unit against a
// result/latency reference model.
module tb_md_unit;

  localparam int unsigned W = 32;
`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [1:0]   op_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         mthi_i;
  logic         mtlo_i;
  logic [W-1:0] wdata_i;
  logic         mf_req_i;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;
  logic         busy_o;
  logic         done_o;
  logic         stall_o;
  logic         dz_o;

  md_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .mthi_i   (mthi_i),
    .mtlo_i   (mtlo_i),
    .wdata_i  (wdata_i),
    .mf_req_i (mf_req_i),
    .hi_o     (hi_o),
    .lo_o     (lo_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .stall_o  (stall_o),
    .dz_o     (dz_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int t0     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    else n_pass = n_pass + 1;
  endfunction

  // Architectural result and done latency of one operation.
  function automatic void md_ref(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] hi, output logic [W-1:0] lo,
                                 output logic dz, output int lat);
    longint sa, sb, sp, q, r;
    longint unsigned ua, ub, pu, mag;
    int early_lat;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    dz = 1'b0;
    hi = '0;
    lo = '0;
    lat = 33;
    mag = (op == 2'b00 && sb < 0) ? longint'(-sb) : ub;
    early_lat = 2;
    for (int i = 0; i < 32; i++) if (mag[i]) early_lat = i + 2;
    case (op)
      2'b00: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; lat = EARLY ? early_lat : 33; end
      2'b01: begin pu = ua * ub; hi = pu[63:32]; lo = pu[31:0]; lat = EARLY ? early_lat : 33; end
      default: begin
        if (b == '0) begin
          hi = a; lo = '1; dz = 1'b1; lat = 1;
        end else if (op == 2'b10) begin
          q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0];
        end else begin
          pu = ua / ub; mag = ua % ub; lo = pu[31:0]; hi = mag[31:0];
        end
      end
    endcase
  endfunction

  // Cycle-level expectation: results appear lat cycles after acceptance.
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  logic         m_busy, m_done, m_dz, p_dz, m_valid = 1'b0;
  int           m_left, m_lat;

  always @(posedge clk) begin
    if (rst) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; m_left = 0; m_valid = 1'b1;
    end else begin
      m_done = 1'b0;
      m_dz   = 1'b0;
      if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_dz = p_dz; m_done = 1'b1; m_busy = 1'b0;
        end
      end else if (start_i) begin
        md_ref(op_i, a_i, b_i, p_hi, p_lo, p_dz, m_lat);
        if (m_lat == 1) begin
          m_hi = p_hi; m_lo = p_lo; m_dz = p_dz; m_done = 1'b1;
        end else begin
          m_left = m_lat - 1; m_busy = 1'b1;
        end
      end else begin
        if (mthi_i) m_hi = wdata_i;
        if (mtlo_i) m_lo = wdata_i;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy_o", busy_o, m_busy);
      chk("done_o", done_o, m_done);
      chk("dz_o", dz_o, m_dz);
      chk("hi_o", hi_o, m_hi);
      chk("lo_o", lo_o, m_lo);
      chk("stall_o", stall_o, m_busy & (start_i | mf_req_i | mthi_i | mtlo_i));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    tick();
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    t0 = cyc;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done_o === 1'b1) begin
        lat = cyc - t0;
        break;
      end
    end
    if (lat < 0) chk("done_timeout", done_o, 1'b1);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = 32'h8000_0000;
      2: v = '1;
      3: v = W'($urandom_range(1, 15));
      4: v = -W'($urandom_range(1, 15));
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  int lat, t1, ndone;

  initial begin
    rst = 1'b1; start_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0;
    mthi_i = 1'b0; mtlo_i = 1'b0; wdata_i = '0; mf_req_i = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);

    // MULT -3 * 7
    issue(2'b00, 32'hFFFF_FFFD, 32'd7);
    @(negedge clk);
    chk("mult_busy_c1", busy_o, 1);
    wait_done(lat);
    chk("mult_lat", lat, EARLY ? 4 : 33);
    chk("mult_hi", hi_o, 32'hFFFF_FFFF);
    chk("mult_lo", lo_o, 32'hFFFF_FFEB);
    chk("mult_busy_done", busy_o, 0);

    // DIVU 100 / 7
    issue(2'b11, 32'd100, 32'd7);
    wait_done(lat);
    chk("divu_lat", lat, 33);
    chk("divu_lo", lo_o, 32'h0000_000E);
    chk("divu_hi", hi_o, 32'h0000_0002);

    // DIV -7 / 2, then MIN / -1
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat);
    chk("div_neg_lo", lo_o, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi_o, 32'hFFFF_FFFF);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat);
    chk("div_ovf_lo", lo_o, 32'h8000_0000);
    chk("div_ovf_hi", hi_o, 32'h0000_0000);

    // DIV by zero
    issue(2'b10, 32'd5, 32'd0);
    wait_done(lat);
    chk("dz_lat", lat, 1);
    chk("dz_flag", dz_o, 1);
    chk("dz_hi", hi_o, 32'd5);
    chk("dz_lo", lo_o, 32'hFFFF_FFFF);

    // Requests while busy are stalled and ignored
    issue(2'b11, 32'd1000, 32'd3);
    while (cyc < t0 + 10) tick();
    start_i = 1'b1; op_i = 2'b01; a_i = 32'd5; b_i = 32'd6;
    mf_req_i = 1'b1; mtlo_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk("busy_stall", stall_o, 1);
      chk("busy_hold_hi", hi_o, 32'd5);
      chk("busy_hold_lo", lo_o, 32'hFFFF_FFFF);
      tick();
    end
    start_i = 1'b0; mf_req_i = 1'b0; mtlo_i = 1'b0;
    wait_done(lat);
    chk("inter_lat", lat, 33);
    chk("inter_lo", lo_o, 32'h0000_014D);
    chk("inter_hi", hi_o, 32'h0000_0001);
    @(negedge clk);
    chk("inter_no_second", busy_o, 0);
    issue(2'b01, 32'd5, 32'd6);
    wait_done(lat);
    chk("reissue_lo", lo_o, 32'd30);
    chk("reissue_hi", hi_o, 32'd0);

    // MTHI/MTLO in idle
    tick();
    mthi_i = 1'b1; wdata_i = 32'h1234_5678;
    tick();
    mthi_i = 1'b0; mtlo_i = 1'b1; wdata_i = 32'h0BAD_F00D;
    tick();
    mtlo_i = 1'b0;
    @(negedge clk);
    chk("mthi_val", hi_o, 32'h1234_5678);
    chk("mtlo_val", lo_o, 32'h0BAD_F00D);

    // Reset in the middle of a multiply
    issue(2'b01, 32'h0000_1234, 32'h0000_5678);
    while (cyc < t0 + 15) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_busy", busy_o, 0);
    chk("mrst_hi", hi_o, 0);
    chk("mrst_lo", lo_o, 0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o === 1'b1) ndone++;
    end
    chk("mrst_no_done", ndone, 0);

    // Back-to-back: new start in the done cycle
    issue(2'b11, 32'd100, 32'd7);
    while (cyc < t0 + 33) tick();
    start_i = 1'b1; op_i = 2'b01; a_i = 32'd9; b_i = 32'd3;
    t1 = cyc;
    @(negedge clk);
    chk("b2b_done", done_o, 1);
    chk("b2b_lo", lo_o, 32'h0000_000E);
    tick();
    start_i = 1'b0;
    @(negedge clk);
    chk("b2b_busy", busy_o, 1);
    t0 = t1;
    wait_done(lat);
    chk("multu_lat", lat, EARLY ? 3 : 33);
    chk("multu_hi", hi_o, 32'd0);
    chk("multu_lo", lo_o, 32'd27);

    // Randomized traffic
    for (int n = 0; n < 6000; n++) begin
      tick();
      rst      = ($urandom_range(0, 199) == 0);
      start_i  = ($urandom_range(0, 3) == 0);
      op_i     = 2'($urandom_range(0, 3));
      a_i      = pick();
      b_i      = pick();
      mthi_i   = ($urandom_range(0, 9) == 0);
      mtlo_i   = ($urandom_range(0, 9) == 0);
      wdata_i  = W'($urandom);
      mf_req_i = ($urandom_range(0, 3) == 0);
    end
    tick();
    rst = 1'b0; start_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0; mf_req_i = 1'b0;
    repeat (40) tick();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
